// File: rtl/sync_mem_pkg.sv
// Shared types and default geometry for the sync_mem block.
package sync_mem_pkg;

  localparam int W_DEFAULT = 32;
  localparam int A_DEFAULT = 12;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

endpackage

// File: rtl/sync_mem_if.sv
// Request/response channel bundle for sync_mem; master drives requests, slave answers.
interface sync_mem_if
  import sync_mem_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int A = A_DEFAULT
);

  logic           req_valid;
  logic           req_ready;
  logic           req_write;
  logic [A-1:0]   req_addr;
  logic [W-1:0]   req_wdata;
  logic [W/8-1:0] req_be;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_rdata;
  logic           busy;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    input  req_ready, resp_valid, resp_rdata, busy
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
    output req_ready, resp_valid, resp_rdata, busy
  );

endinterface

// File: rtl/sync_mem_array.sv
// Word storage with byte-lane writes and a registered read port.
module sync_mem_array
  import sync_mem_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int A = A_DEFAULT
) (
  input  logic           clk,
  input  logic           we,
  input  logic [A-1:0]   addr,
  input  logic [W-1:0]   wdata,
  input  logic [W/8-1:0] be,
  output logic [W-1:0]   rdata
);

  localparam int NB = W / 8;

  logic [W-1:0] mem [2**A];

  // Read returns the pre-write word; the controller never reads and writes in one cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sync_mem.sv
// Synchronous memory controller: valid/ready requests, one-cycle read responses.
// Define MEM_CLEAR_EN to zero the whole array after every reset.
module sync_mem
  import sync_mem_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int A = A_DEFAULT
) (
  input  logic      clk,
  input  logic      rst,
  sync_mem_if.slave bus
);

  localparam int NB = W / 8;

  state_t          state;
  logic            resp_valid;
  logic [A-1:0]    last_addr;
  logic            accept;
  logic            rd_accept;
  logic            arr_we;
  logic [A-1:0]    arr_addr;
  logic [W-1:0]    arr_wdata;
  logic [NB-1:0]   arr_be;
  logic [W-1:0]    arr_rdata;

  assign bus.req_ready  = !rst && (state == READY) && !(resp_valid && !bus.resp_ready);
  assign accept         = bus.req_valid && bus.req_ready;
  assign rd_accept      = accept && !bus.req_write;
  assign bus.resp_valid = resp_valid;
  // Array address is parked on the last read while idle, so its output stays stable.
  assign bus.resp_rdata = resp_valid ? arr_rdata : '0;

`ifdef MEM_CLEAR_EN
  logic [A-1:0] clr_addr;

  assign bus.busy = (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
    end else if (state == CLEAR) begin
      if (clr_addr == {A{1'b1}}) state <= READY;
      else                       clr_addr <= clr_addr + 1'b1;
    end
  end
`else
  assign bus.busy = 1'b0;
  assign state    = READY;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      last_addr  <= '0;
    end else if (rd_accept) begin
      resp_valid <= 1'b1;
      last_addr  <= bus.req_addr;
    end else if (bus.resp_ready) begin
      resp_valid <= 1'b0;
    end
  end

  always_comb begin
    arr_we    = accept && bus.req_write;
    arr_addr  = accept ? bus.req_addr : last_addr;
    arr_wdata = bus.req_wdata;
    arr_be    = bus.req_be;
`ifdef MEM_CLEAR_EN
    if (state == CLEAR) begin
      arr_we    = 1'b1;
      arr_addr  = clr_addr;
      arr_wdata = '0;
      arr_be    = '1;
    end
`endif
  end

  sync_mem_array #(.W(W), .A(A)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (arr_addr),
    .wdata (arr_wdata),
    .be    (arr_be),
    .rdata (arr_rdata)
  );

endmodule
